// File: rtl/pwm_duty_meter_if.sv
// Signal bundle for pwm_duty_meter: the PWM/clear inputs and the measurement results.
// The master side drives the PWM stream; the slave side is the meter.
interface pwm_duty_meter_if;
  logic       pwm_in;
  logic       sync_err_clr;
  logic [7:0] duty;
  logic       duty_valid;
  logic       locked;
  logic       sync_err;

  modport master (
    output pwm_in,
    output sync_err_clr,
    input  duty,
    input  duty_valid,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  pwm_in,
    input  sync_err_clr,
    output duty,
    output duty_valid,
    output locked,
    output sync_err
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// Measures PWM high-time over 256-cycle windows aligned to a pwm_in rising edge.
// Optional feature macro PWM_DUTY_METER_AVG_EN: report the rolling average of the last 4 windows.
module pwm_duty_meter (
  input  logic             clk,
  input  logic             rst,
  pwm_duty_meter_if.slave  bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic [0:0] state_q,      state_d;
  logic [7:0] idle_cnt_q,   idle_cnt_d;
  logic [7:0] win_cnt_q,    win_cnt_d;
  logic [8:0] high_cnt_q,   high_cnt_d;
  logic       prev_pwm_q,   prev_pwm_d;
  logic [7:0] duty_q,       duty_d;
  logic       duty_valid_q, duty_valid_d;
  logic       sync_err_q,   sync_err_d;

  logic       rise;
  logic       timeout;
  logic       win_done;
  logic       resync;
  logic [8:0] high_total;
  logic [7:0] win_result;

  assign rise       = bus.pwm_in & ~prev_pwm_q;
  assign high_total = high_cnt_q + {8'd0, bus.pwm_in};
  assign win_result = high_total[8] ? 8'hFF : high_total[7:0];

  // win_cnt holds the index of the sample being taken, so the edge cycle (index 0) moves it to 1.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    win_cnt_d  = win_cnt_q;
    high_cnt_d = high_cnt_q;
    prev_pwm_d = bus.pwm_in;
    timeout    = 1'b0;
    win_done   = 1'b0;
    resync     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = MEASURE;
          idle_cnt_d = 8'd0;
          win_cnt_d  = 8'd1;
          high_cnt_d = 9'd1;
        end else begin
          timeout    = (idle_cnt_q == 8'hFF);
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: begin
        if (rise && (win_cnt_q != 8'd0)) begin
          resync     = 1'b1;
          win_cnt_d  = 8'd1;
          high_cnt_d = 9'd1;
        end else if (win_cnt_q == 8'hFF) begin
          win_done   = 1'b1;
          win_cnt_d  = 8'd0;
          high_cnt_d = 9'd0;
        end else begin
          win_cnt_d  = win_cnt_q + 8'd1;
          high_cnt_d = high_total;
        end
      end
    endcase
  end

`ifdef PWM_DUTY_METER_AVG_EN
  logic [2:0][7:0] hist_q,     hist_d;
  logic [1:0]      hist_cnt_q, hist_cnt_d;
  logic [9:0]      avg_sum;

  assign avg_sum = {2'b00, win_result} + {2'b00, hist_q[0]} +
                   {2'b00, hist_q[1]}  + {2'b00, hist_q[2]};

  // hist_cnt counts stored earlier windows; a report needs three of them plus the current one.
  always_comb begin
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    if (resync || (state_q == IDLE)) begin
      hist_d     = '0;
      hist_cnt_d = 2'd0;
    end else if (win_done) begin
      hist_d = {hist_q[1], hist_q[0], win_result};
      if (hist_cnt_q != 2'd3) begin
        hist_cnt_d = hist_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q     <= '0;
      hist_cnt_q <= 2'd0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`endif

  always_comb begin
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    sync_err_d   = (sync_err_q & ~bus.sync_err_clr) | resync;
    if (timeout) begin
      duty_d       = 8'd0;
      duty_valid_d = 1'b1;
    end else if (win_done) begin
`ifdef PWM_DUTY_METER_AVG_EN
      if (hist_cnt_q == 2'd3) begin
        duty_d       = avg_sum[9:2];
        duty_valid_d = 1'b1;
      end
`else
      duty_d       = win_result;
      duty_valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idle_cnt_q   <= 8'd0;
      win_cnt_q    <= 8'd0;
      high_cnt_q   <= 9'd0;
      prev_pwm_q   <= 1'b0;
      duty_q       <= 8'd0;
      duty_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      high_cnt_q   <= high_cnt_d;
      prev_pwm_q   <= prev_pwm_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.locked     = (state_q == MEASURE);
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: a sample-list reference model queues expected
// duty reports while a negedge monitor compares every cycle against the DUT.
module tb_pwm_duty_meter;

  logic clk = 1'b0;
  logic rst;

  pwm_duty_meter_if bus ();

  pwm_duty_meter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] duty;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: the current window is kept as a list of samples and reduced by summation.
  bit         m_locked = 1'b0;
  bit         m_sync   = 1'b0;
  bit         m_prev   = 1'b0;
  logic [7:0] m_duty   = 8'd0;
  int         m_idle   = 0;
  bit         m_win[$];
  int         m_hist[$];

  // Model view of what the DUT outputs should show during the current cycle.
  bit         c_locked = 1'b0;
  bit         c_sync   = 1'b0;
  logic [7:0] c_duty   = 8'd0;

  // Cycle counter: number of rising clock edges seen so far.
  always @(posedge clk) cyc = cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic modelReport(input int r);
    exp_t e;
`ifdef PWM_DUTY_METER_AVG_EN
    int s;
    m_hist.push_back(r);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    if (m_hist.size() == 4) begin
      s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      m_duty = 8'(s / 4);
      e.due  = cyc + 1;
      e.duty = m_duty;
      exp_q.push_back(e);
    end
`else
    m_duty = 8'(r);
    e.due  = cyc + 1;
    e.duty = m_duty;
    exp_q.push_back(e);
`endif
  endtask

  task automatic modelStep(input bit p, input bit c, input bit r);
    bit   rise;
    bit   err;
    int   s;
    exp_t e;
    err = 1'b0;
    if (!r) begin
      m_locked = 1'b0;
      m_sync   = 1'b0;
      m_prev   = 1'b0;
      m_duty   = 8'd0;
      m_idle   = 0;
      m_win.delete();
      m_hist.delete();
      return;
    end
    rise   = p && !m_prev;
    m_prev = p;
    if (!m_locked) begin
      if (rise) begin
        m_locked = 1'b1;
        m_idle   = 0;
        m_win.delete();
        m_hist.delete();
        m_win.push_back(p);
      end else begin
        m_idle++;
        if (m_idle == 256) begin
          m_idle = 0;
          m_duty = 8'd0;
          e.due  = cyc + 1;
          e.duty = 8'd0;
          exp_q.push_back(e);
        end
      end
    end else begin
      if (rise && (m_win.size() != 0)) begin
        err = 1'b1;
        m_win.delete();
        m_hist.delete();
      end
      m_win.push_back(p);
      if (m_win.size() == 256) begin
        s = 0;
        foreach (m_win[i]) s += int'(m_win[i]);
        m_win.delete();
        modelReport((s > 255) ? 255 : s);
      end
    end
    m_sync = err || (m_sync && !c);
  endtask

  // One clock of stimulus: snapshot the model's post-edge view, then drive and advance the model.
  task automatic applyStimulus(input bit p, input bit c, input bit r);
    @(posedge clk);
    c_locked = m_locked;
    c_sync   = m_sync;
    c_duty   = m_duty;
    mon_en   = 1'b1;
    #1;
    bus.pwm_in       = p;
    bus.sync_err_clr = c;
    rst              = r;
    modelStep(p, c, r);
  endtask

  task automatic genPeriod(input int d, input int clrAt);
    for (int i = 0; i < 256; i++) applyStimulus(i < d, i == clrAt, 1'b1);
  endtask

  // Period with an extra rising edge at pos (pos > d), followed by 255 low cycles so that
  // the generator that follows lines up with the restarted window.
  task automatic glitchRealign(input int d, input int pos, input bit clr);
    for (int i = 0; i < pos; i++) applyStimulus(i < d, 1'b0, 1'b1);
    applyStimulus(1'b1, clr, 1'b1);
    for (int i = 0; i < 255; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare status every cycle and pop the scoreboard when a report is due.
  task automatic checkOutput();
    exp_t e;
    cmp("locked", {31'd0, bus.locked}, {31'd0, c_locked});
    cmp("sync_err", {31'd0, bus.sync_err}, {31'd0, c_sync});
    cmp("duty", {24'd0, bus.duty}, {24'd0, c_duty});
    if ((exp_q.size() != 0) && (exp_q[0].due <= cyc)) begin
      e = exp_q.pop_front();
      cmp("duty_valid", {31'd0, bus.duty_valid}, 32'd1);
      cmp("report_duty", {24'd0, bus.duty}, {24'd0, e.duty});
    end else begin
      cmp("duty_valid", {31'd0, bus.duty_valid}, 32'd0);
    end
  endtask

  always @(negedge clk) if (mon_en) checkOutput();

  // Watchdog so the run always ends even if stimulus stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst              = 1'b0;
    bus.pwm_in       = 1'b0;
    bus.sync_err_clr = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    // Idle timeout with pwm held low, then lock on a 100-high generator.
    repeat (300) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (4) genPeriod(100, -1);

    // Random duties, full-scale, and zero duty while locked.
    for (int k = 0; k < 5; k++) genPeriod(int'($urandom_range(1, 254)), -1);
    repeat (2) genPeriod(255, -1);
    repeat (2) genPeriod(0, -1);

    // Forced high for a full window saturates, then resync off it.
    repeat (256) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    glitchRealign(10, 60, 1'b0);

    // Off-boundary edge at index 40, clear, then clear coincident with a new error.
    glitchRealign(20, 40, 1'b0);
    genPeriod(60, 30);
    glitchRealign(30, 100, 1'b1);
    genPeriod(70, 5);

    // Reset in mid-window, then relock on an edge on the first cycle after release.
    for (int i = 0; i < 128; i++) applyStimulus(i < 100, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) genPeriod(100, -1);

    // Random periods with occasional glitches and clears.
    for (int k = 0; k < 6; k++) begin
      int d;
      d = int'($urandom_range(1, 200));
      if ($urandom_range(0, 3) == 0)
        glitchRealign(d, d + 1 + int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      else
        genPeriod(d, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1);
    end

    // Fresh lock followed by four distinct window results.
    applyStimulus(1'b0, 1'b0, 1'b0);
    genPeriod(100, -1);
    genPeriod(104, -1);
    genPeriod(108, -1);
    genPeriod(112, -1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    cmp("pending_reports", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 The block SHALL have no parameters; the PWM period SHALL be fixed at 256 clk cycles, matching the upstream 8-bit PWM generator.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 pwm_in  input  1  PWM stream from the upstream generator, same clock domain, no synchronizer.
REQ-005 sync_err_clr  input  1  one-cycle request to clear sync_err.
REQ-006 duty  output  8  last measured high-time, in clk cycles per 256-cycle window.
REQ-007 duty_valid  output  1  one-cycle pulse when duty is updated.
REQ-008 locked  output  1  high while measuring windows aligned to a pwm_in rising edge.
REQ-009 sync_err  output  1  sticky flag for a rising edge seen off the window boundary.

Function
REQ-010 Rising edge SHALL be detected as pwm_in=1 with registered prev_pwm=0.
REQ-011 The FSM SHALL have two states, IDLE and MEASURE.
REQ-012 IDLE: idle_cnt (8-bit) SHALL increment each cycle; a rising edge SHALL move the FSM to MEASURE, set win_cnt=0 and set high_cnt to 1; that edge cycle is window cycle 0.
REQ-013 IDLE timeout: when idle_cnt=255 with no edge, duty SHALL be set to 0, duty_valid SHALL pulse, idle_cnt SHALL wrap to 0, and the FSM SHALL stay in IDLE.
REQ-014 MEASURE: win_cnt SHALL increment 0..255 and wrap; high_cnt SHALL add 1 for each cycle in which pwm_in=1, including cycle 0.
REQ-015 At win_cnt=255, duty SHALL be loaded with min(high_cnt including that cycle, 255), and duty_valid SHALL pulse on the next clock edge (1-cycle latency from the last sample).
REQ-016 At wrap, high_cnt SHALL restart from that cycle's sample, windows SHALL continue back-to-back, and duty=0 windows SHALL still report.
REQ-017 A rising edge with win_cnt=0 SHALL be normal; the window SHALL continue.
REQ-018 A rising edge with win_cnt!=0 SHALL discard the partial window (no duty_valid), set sync_err=1, and restart the window with that cycle as cycle 0; locked SHALL stay 1.
REQ-019 high_cnt SHALL be 9-bit internally; duty SHALL saturate at 255.
REQ-020 sync_err_clr SHALL clear sync_err on the next edge; if a new error occurs in the same cycle, sync_err SHALL remain 1 (error wins).
REQ-021 locked SHALL be 0 in IDLE and 1 in MEASURE.
REQ-022 duty SHALL hold its value between valid pulses.

Reset
REQ-023 With rst=0 at a clk edge: state=IDLE, idle_cnt=0, win_cnt=0, high_cnt=0, prev_pwm=0, duty=0, duty_valid=0, locked=0, sync_err=0, average history cleared.
REQ-024 Reset mid-window SHALL discard the partial measurement with no duty_valid.
REQ-025 pwm_in=1 on the first cycle after reset release SHALL count as a rising edge.

Configuration
REQ-026 Macro PWM_DUTY_METER_AVG_EN.
- Defined: duty SHALL be the average of the last 4 window results (10-bit sum >>2, truncating).
- Defined: duty_valid SHALL pulse only once 4 windows have completed since lock or the last resync; each later window SHALL produce a valid pulse with the rolling average.
- Defined: a resync or reset SHALL clear the history; the IDLE timeout SHALL report 0 unaveraged.
- Not defined: every window SHALL report its raw result; no averaging logic SHALL be present.

Verification
REQ-027 Upstream generator with in=100 after reset -> first duty_valid 256 cycles after the first rising edge (+1 latency), duty=100, locked=1, sync_err=0; repeats every 256 cycles.
REQ-028 pwm_in held 0 from reset -> duty_valid at cycle 256 with duty=0, locked=0; generator in=0 after lock -> duty=0 every window, locked stays 1.
REQ-029 in=255 -> duty=255; pwm_in forced high for a full window -> duty=255 (saturated).
REQ-030 Rising edge injected at win_cnt=40 -> sync_err=1, no valid for that window, next valid 256 cycles after the injected edge; sync_err_clr pulse -> sync_err=0; clr coincident with a new off-boundary edge -> sync_err=1.
REQ-031 rst=0 at win_cnt=128 -> all outputs 0 next cycle, no duty_valid; relock on the next edge.
REQ-032 With PWM_DUTY_METER_AVG_EN, window results 100,104,108,112 -> first duty_valid after the 4th window with duty=106, no earlier valid; without the macro -> four valids 100,104,108,112.
